// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and constants for the IF/MEM single-port RAM arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0] LenByte = 2'b00;
  localparam logic [1:0] LenHalf = 2'b01;
  localparam logic [1:0] LenWord = 2'b10;

  localparam logic [31:0] ZeroWord = '0;
  localparam logic [7:0]  Zero8    = '0;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StDone
  } state_t;

  typedef enum logic {
    OwnIF,
    OwnMEM
  } owner_t;

  // Length code 2'b11 is treated as a full word.
  function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
    case (len)
      LenByte: return 3'd1;
      LenHalf: return 3'd2;
      LenWord: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_lane.sv
// Byte-index insert (read assembly) and extract (write disassembly) mux.
module mem_byte_lane
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [7:0]        i_byte,
  input  logic [1:0]        i_ins_idx,
  output logic [DATA_W-1:0] o_word,
  input  logic [DATA_W-1:0] i_sel_word,
  input  logic [1:0]        i_sel_idx,
  output logic [7:0]        o_sel_byte
);

  always_comb begin
    o_word = i_word;
    o_word[{i_ins_idx, 3'b000} +: 8] = i_byte;
  end

  always_comb begin
    o_sel_byte = Zero8;
    o_sel_byte = i_sel_word[{i_sel_idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared 8-bit RAM port: MEM has priority over IF,
// requests are serialised into byte accesses over a little-endian 32-bit word.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_inst_o,
  input  logic              flush_i,
  input  logic              mem_req_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              if_busy_o,
  output logic              mem_busy_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o
);

  state_t            r_state,  w_state_nx;
  owner_t            r_owner,  w_owner_nx;
  logic [ADDR_W-1:0] r_base,   w_base_nx;
  logic [2:0]        r_nbytes, w_nbytes_nx;
  logic              r_wr,     w_wr_nx;
  logic [DATA_W-1:0] r_wdata,  w_wdata_nx;
  logic [DATA_W-1:0] r_rdata,  w_rdata_nx;
  logic [2:0]        r_cnt,    w_cnt_nx;

  logic [DATA_W-1:0] w_ins_word;
  logic [7:0]        w_sel_byte;
  logic [1:0]        w_ins_idx;
  logic [ADDR_W-1:0] w_ram_a;
  logic [7:0]        w_ram_dout;
  logic              w_ram_wr;

  // Read byte arriving at cnt belongs to the address issued at cnt-1.
  assign w_ins_idx = r_cnt[1:0] - 2'd1;

  mem_byte_lane #(
    .DATA_W(DATA_W)
  ) u_lane (
    .i_word    (r_rdata),
    .i_byte    (ram_din_i),
    .i_ins_idx (w_ins_idx),
    .o_word    (w_ins_word),
    .i_sel_word(r_wdata),
    .i_sel_idx (r_cnt[1:0]),
    .o_sel_byte(w_sel_byte)
  );

  always_comb begin
    w_state_nx  = r_state;
    w_owner_nx  = r_owner;
    w_base_nx   = r_base;
    w_nbytes_nx = r_nbytes;
    w_wr_nx     = r_wr;
    w_wdata_nx  = r_wdata;
    w_rdata_nx  = r_rdata;
    w_cnt_nx    = r_cnt;
    w_ram_a     = '0;
    w_ram_dout  = Zero8;
    w_ram_wr    = 1'b0;

    case (r_state)
      StIdle: begin
        if (mem_req_i) begin
          w_owner_nx  = OwnMEM;
          w_base_nx   = mem_addr_i;
          w_nbytes_nx = len_to_nbytes(mem_len_i);
          w_wr_nx     = mem_wr_i;
          w_wdata_nx  = mem_wdata_i;
          w_rdata_nx  = ZeroWord;
          w_cnt_nx    = '0;
          w_state_nx  = StXfer;
        end else if (if_req_i && !flush_i) begin
          w_owner_nx  = OwnIF;
          w_base_nx   = if_addr_i;
          w_nbytes_nx = 3'd4;
          w_wr_nx     = 1'b0;
          w_wdata_nx  = ZeroWord;
          w_rdata_nx  = ZeroWord;
          w_cnt_nx    = '0;
          w_state_nx  = StXfer;
        end
      end

      StXfer: begin
        w_ram_a  = r_base + ADDR_W'(r_cnt);
        w_cnt_nx = r_cnt + 3'd1;
        if (r_owner == OwnIF && flush_i) begin
          w_state_nx = StIdle;
        end else if (r_wr) begin
          w_ram_wr   = 1'b1;
          w_ram_dout = w_sel_byte;
          if (r_cnt == r_nbytes - 3'd1) w_state_nx = StDone;
        end else begin
          if (r_cnt != 3'd0) w_rdata_nx = w_ins_word;
          if (r_cnt == r_nbytes) w_state_nx = StDone;
        end
      end

      StDone: w_state_nx = StIdle;

      default: w_state_nx = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_owner  <= OwnIF;
      r_base   <= '0;
      r_nbytes <= 3'd4;
      r_wr     <= 1'b0;
      r_wdata  <= ZeroWord;
      r_rdata  <= ZeroWord;
      r_cnt    <= '0;
    end else if (rdy) begin
      r_state  <= w_state_nx;
      r_owner  <= w_owner_nx;
      r_base   <= w_base_nx;
      r_nbytes <= w_nbytes_nx;
      r_wr     <= w_wr_nx;
      r_wdata  <= w_wdata_nx;
      r_rdata  <= w_rdata_nx;
      r_cnt    <= w_cnt_nx;
    end
  end

  // Done is qualified by rdy so a frozen DONE state still yields one pulse.
  assign if_done_o   = rdy && (r_state == StDone) && (r_owner == OwnIF);
  assign mem_done_o  = rdy && (r_state == StDone) && (r_owner == OwnMEM);
  assign if_busy_o   = if_req_i  & ~if_done_o;
  assign mem_busy_o  = mem_req_i & ~mem_done_o;
  assign if_inst_o   = r_rdata;
  assign mem_rdata_o = r_rdata;
  assign ram_a_o     = w_ram_a;
  assign ram_dout_o  = w_ram_dout;
  assign ram_wr_o    = w_ram_wr & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a byte-array memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_done_o;
  logic [31:0] if_inst_o;
  logic        flush_i;
  logic        mem_req_i;
  logic        mem_wr_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic        if_busy_o;
  logic        mem_busy_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  ram_dout_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;

  logic [7:0]  ram       [0:1023];
  logic [7:0]  model_mem [0:1023];
  logic        copy_req;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o),
    .if_inst_o(if_inst_o), .flush_i(flush_i),
    .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .mem_len_i(mem_len_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .if_busy_o(if_busy_o), .mem_busy_o(mem_busy_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o),
    .ram_wr_o(ram_wr_o)
  );

  // Synchronous RAM, one cycle read latency, frozen while rdy is low.
  always @(posedge clk) begin
    if (copy_req) begin
      for (int i = 0; i < 1024; i++) ram[i] <= model_mem[i];
    end else if (rdy) begin
      if (ram_wr_o) ram[ram_a_o[9:0]] <= ram_dout_o;
      ram_din_i <= ram[ram_a_o[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned idx(input logic [31:0] a);
    return int'(a[9:0]);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr, input int unsigned nb);
    logic [31:0] w;
    w = '0;
    for (int unsigned k = 0; k < nb; k++)
      w = w | (32'(model_mem[idx(addr + k)]) << (8 * k));
    return w;
  endfunction

  function automatic int unsigned len_bytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  task automatic sync_ram();
    @(negedge clk);
    copy_req = 1'b1;
    @(negedge clk);
    copy_req = 1'b0;
  endtask

  task automatic run_mem(input logic wr, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned nb, lat, wcnt;
    logic [31:0] exp;
    bit done;
    @(negedge clk);
    nb  = len_bytes(len);
    exp = model_word(addr, nb);
    mem_wr_i = wr; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wdata;
    mem_req_i = 1'b1;
    lat = 0; wcnt = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ram_wr_o) begin
        chk("st_addr", ram_a_o, addr + wcnt);
        chk("st_byte", 32'(ram_dout_o), 32'(8'(wdata >> (8 * wcnt))));
        wcnt++;
      end
      if (mem_done_o) begin
        done = 1'b1;
        chk("mem_busy_at_done", 32'(mem_busy_o), 32'd0);
      end
    end
    mem_req_i = 1'b0;
    chk("mem_latency", lat, wr ? nb + 1 : nb + 2);
    if (wr) begin
      chk("st_count", wcnt, nb);
      for (int unsigned k = 0; k < nb; k++)
        model_mem[idx(addr + k)] = 8'(wdata >> (8 * k));
      for (int unsigned k = 0; k < 4; k++)
        chk("ram_byte", 32'(ram[idx(addr + k)]), 32'(model_mem[idx(addr + k)]));
    end else begin
      chk("st_count_ld", wcnt, 0);
      chk("ld_data", mem_rdata_o, exp);
    end
  endtask

  task automatic run_if(input logic [31:0] addr);
    int unsigned lat;
    logic [31:0] exp;
    bit done;
    @(negedge clk);
    exp = model_word(addr, 4);
    if_addr_i = addr; if_req_i = 1'b1;
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat <= 4) chk("if_addr", ram_a_o, addr + lat - 1);
      if (ram_wr_o) chk("if_no_write", 32'(ram_wr_o), 32'd0);
      if (if_done_o) done = 1'b1;
    end
    if_req_i = 1'b0;
    chk("if_latency", lat, 6);
    chk("if_inst", if_inst_o, exp);
  endtask

  task automatic run_stall(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned lat, wcnt;
    logic [31:0] exp;
    bit done;
    @(negedge clk);
    exp = model_word(addr, 4);
    mem_wr_i = wr; mem_len_i = 2'b10; mem_addr_i = addr; mem_wdata_i = wdata;
    mem_req_i = 1'b1;
    lat = 0; wcnt = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat >= 3 && lat <= 5) begin
        chk("stall_wr", 32'(ram_wr_o), 32'd0);
        chk("stall_addr", ram_a_o, addr + 1);
      end
      if (ram_wr_o) wcnt++;
      if (mem_done_o) done = 1'b1;
      if (lat == 2) rdy = 1'b0;
      if (lat == 5) rdy = 1'b1;
    end
    mem_req_i = 1'b0;
    rdy = 1'b1;
    chk("stall_latency", lat, wr ? 8 : 9);
    if (wr) begin
      chk("stall_st_count", wcnt, 4);
      for (int unsigned k = 0; k < 4; k++) begin
        model_mem[idx(addr + k)] = 8'(wdata >> (8 * k));
        chk("stall_ram_byte", 32'(ram[idx(addr + k)]), 32'(model_mem[idx(addr + k)]));
      end
    end else begin
      chk("stall_ld_data", mem_rdata_o, exp);
    end
  endtask

  initial begin
    int unsigned lat;
    bit done;
    rst = 1'b1; rdy = 1'b1; flush_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_wr_i = 1'b0; mem_len_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    copy_req = 1'b1;
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'($urandom);
    model_mem[10'h100] = 8'h13; model_mem[10'h101] = 8'h05;
    model_mem[10'h102] = 8'h00; model_mem[10'h103] = 8'h00;
    model_mem[10'h010] = 8'h80;
    @(negedge clk);
    copy_req = 1'b0;
    @(negedge clk);

    chk("rst_if_done",  32'(if_done_o),  32'd0);
    chk("rst_mem_done", 32'(mem_done_o), 32'd0);
    chk("rst_if_busy",  32'(if_busy_o),  32'd0);
    chk("rst_mem_busy", 32'(mem_busy_o), 32'd0);
    chk("rst_ram_wr",   32'(ram_wr_o),   32'd0);
    chk("rst_ram_a",    ram_a_o,         32'd0);
    chk("rst_ram_dout", 32'(ram_dout_o), 32'd0);
    chk("rst_inst",     if_inst_o,       32'd0);
    chk("rst_rdata",    mem_rdata_o,     32'd0);
    rst = 1'b0;

    // Fetch of a known instruction word
    run_if(32'h0000_0100);
    chk("if_fetch_word", if_inst_o, 32'h0000_0513);

    // Halfword store
    run_mem(1'b1, 2'b01, 32'h0000_2000, 32'hDEAD_BEEF);

    // Contention: MEM wins, IF waits and is granted right after MEM DONE
    @(negedge clk);
    if_addr_i = 32'h0000_0100; if_req_i = 1'b1;
    mem_wr_i = 1'b0; mem_len_i = 2'b00; mem_addr_i = 32'h0000_0010; mem_req_i = 1'b1;
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      chk("cont_if_busy", 32'(if_busy_o), 32'd1);
      if (mem_done_o) done = 1'b1;
    end
    mem_req_i = 1'b0;
    chk("cont_mem_latency", lat, 3);
    chk("cont_mem_rdata", mem_rdata_o, 32'h0000_0080);
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 2) chk("cont_if_grant_addr", ram_a_o, 32'h0000_0100);
      if (!if_done_o) chk("cont_if_busy2", 32'(if_busy_o), 32'd1);
      if (if_done_o) done = 1'b1;
    end
    if_req_i = 1'b0;
    chk("cont_if_latency", lat, 7);
    chk("cont_if_inst", if_inst_o, 32'h0000_0513);

    // Flush mid-fetch, then flush blocking a grant, then a clean fetch
    @(negedge clk);
    if_addr_i = 32'h0000_0300; if_req_i = 1'b1;
    @(negedge clk);
    chk("fl_cnt0_addr", ram_a_o, 32'h0000_0300);
    @(negedge clk);
    chk("fl_cnt1_addr", ram_a_o, 32'h0000_0301);
    flush_i = 1'b1; if_req_i = 1'b0;
    @(negedge clk);
    chk("fl_no_done", 32'(if_done_o), 32'd0);
    chk("fl_idle_addr", ram_a_o, 32'd0);
    chk("fl_idle_wr", 32'(ram_wr_o), 32'd0);
    if_addr_i = 32'h0000_0200; if_req_i = 1'b1;
    @(negedge clk);
    chk("fl_no_grant", ram_a_o, 32'd0);
    chk("fl_no_done2", 32'(if_done_o), 32'd0);
    chk("fl_pending", 32'(if_busy_o), 32'd1);
    flush_i = 1'b0; if_req_i = 1'b0;
    run_if(32'h0000_0200);

    // rdy stalls
    run_stall(1'b0, 32'h0000_0100, 32'h0);
    run_stall(1'b1, 32'h0000_0040, 32'hA5C3_5A3C);
    run_stall(1'b0, 32'h0000_0040, 32'h0);

    // Address wrap-around at the top of the address space
    run_mem(1'b1, 2'b11, 32'hFFFF_FFFF, 32'h1234_5678);
    run_mem(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0);

    // Randomized traffic against the memory model
    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) run_if($urandom);
      else run_mem(kind == 2, 2'($urandom_range(0, 3)), $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during an IF transfer at cnt 2
    run_mem(1'b0, 2'b10, 32'h0000_0100, 32'h0);
    @(negedge clk);
    if_addr_i = 32'h0000_0100; if_req_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rm_cnt2_addr", ram_a_o, 32'h0000_0102);
    rst = 1'b1; if_req_i = 1'b0;
    @(negedge clk);
    chk("rm_ram_wr",   32'(ram_wr_o),   32'd0);
    chk("rm_ram_a",    ram_a_o,         32'd0);
    chk("rm_ram_dout", 32'(ram_dout_o), 32'd0);
    chk("rm_if_done",  32'(if_done_o),  32'd0);
    chk("rm_inst",     if_inst_o,       32'd0);
    chk("rm_rdata",    mem_rdata_o,     32'd0);
    chk("rm_if_busy",  32'(if_busy_o),  32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rm_still_no_done", 32'(if_done_o), 32'd0);
    run_if(32'h0000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
